// File: rtl/binario_a_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and the BCD constants used by the output stage.
package binario_a_bcd_pkg;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    CONVIERTE = 2'd1,
    FIN       = 2'd2
  } estado_t;

  // Four BCD digits cover the full 13-bit input range (max 8191).
  localparam int NUM_DIGITOS = 4;

  // Code the display decoder renders as all segments off.
  localparam logic [3:0] BCD_BLANCO = 4'b1111;

  // Saturation digit used when the value does not fit in three digits.
  localparam logic [3:0] BCD_NUEVE  = 4'b1001;

endpackage

// File: rtl/binario_a_bcd_seq_celda_suma3.sv
// Double-dabble correction cell: a BCD nibble that is 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module celda_suma3 (
  input  logic [3:0] entrada,
  output logic [3:0] salida
);

  assign salida = (entrada >= 4'd5) ? (entrada + 4'd3) : entrada;

endmodule

// File: rtl/binario_a_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with a start/busy/done handshake. Results are held in output registers
// that change only when a conversion completes or on reset, so the display
// multiplexer downstream never sees intermediate values.
//
// Optional build macro: BLANQUEO_CEROS_EN enables leading-zero blanking of
// the hundreds and tens digits.
module binario_a_bcd_seq
  import binario_a_bcd_pkg::*;
#(
  parameter int ANCHO_BIN = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ANCHO_BIN-1:0] binario,
  input  logic                 inicio,
  output logic                 ocupado,
  output logic                 listo,
  output logic [3:0]           unidades,
  output logic [3:0]           decenas,
  output logic [3:0]           centenas,
  output logic                 desborde
);

  localparam int ANCHO_BCD = NUM_DIGITOS * 4;
  localparam int ANCHO_SR  = ANCHO_BCD + ANCHO_BIN;
  localparam int ANCHO_CNT = $clog2(ANCHO_BIN + 1);

  // Counter value seen on the edge that performs the final shift.
  localparam logic [ANCHO_CNT-1:0] CNT_ULTIMO = ANCHO_CNT'(ANCHO_BIN - 1);

`ifdef BLANQUEO_CEROS_EN
  localparam logic [3:0] RST_ALTOS = BCD_BLANCO;
`else
  localparam logic [3:0] RST_ALTOS = 4'd0;
`endif

  estado_t                estado;
  estado_t                estado_sig;
  logic                   cargar;
  logic                   desplazar;
  logic                   publicar;

  logic [ANCHO_SR-1:0]    sr;
  logic [ANCHO_SR-1:0]    sr_ajustado;
  logic [ANCHO_BCD-1:0]   bcd_ajustado;
  logic [ANCHO_CNT-1:0]   cnt;

  logic [3:0]             millares;
  logic [3:0]             centenas_sig;
  logic [3:0]             decenas_sig;
  logic [3:0]             unidades_sig;
  logic                   desborde_sig;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) estado <= REPOSO;
    else     estado <= estado_sig;
  end

  // Next-state and datapath control strobes.
  always_comb begin
    // NOTE: every output of this block is defaulted first; a path that left
    // one unassigned would infer a latch.
    estado_sig = estado;
    cargar     = 1'b0;
    desplazar  = 1'b0;
    publicar   = 1'b0;
    case (estado)
      REPOSO: begin
        if (inicio) begin
          cargar     = 1'b1;
          estado_sig = CONVIERTE;
        end
      end
      CONVIERTE: begin
        desplazar = 1'b1;
        if (cnt == CNT_ULTIMO) estado_sig = FIN;
      end
      FIN: begin
        publicar   = 1'b1;
        estado_sig = REPOSO;
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // Busy covers CONVIERTE and FIN; a new request is ignored until REPOSO.
  assign ocupado = (estado != REPOSO);

  // Add-3 correction on every BCD nibble ahead of the shift.
  for (genvar i = 0; i < NUM_DIGITOS; i++) begin : g_celda
    celda_suma3 u_celda (
      .entrada (sr[ANCHO_BIN + 4*i +: 4]),
      .salida  (bcd_ajustado[4*i +: 4])
    );
  end

  assign sr_ajustado = {bcd_ajustado, sr[ANCHO_BIN-1:0]};

  // Shift register and bit counter: load on accept, correct-and-shift while
  // converting, hold otherwise so FIN can read the finished digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (cargar) begin
      sr  <= {{ANCHO_BCD{1'b0}}, binario};
      cnt <= '0;
    end else if (desplazar) begin
      sr  <= sr_ajustado << 1;
      cnt <= cnt + ANCHO_CNT'(1);
    end
  end

  // Digit values to publish, with saturation and optional blanking.
  always_comb begin
    millares     = sr[ANCHO_BIN + 12 +: 4];
    centenas_sig = sr[ANCHO_BIN + 8  +: 4];
    decenas_sig  = sr[ANCHO_BIN + 4  +: 4];
    unidades_sig = sr[ANCHO_BIN      +: 4];
    desborde_sig = (millares != 4'd0);
    if (desborde_sig) begin
      centenas_sig = BCD_NUEVE;
      decenas_sig  = BCD_NUEVE;
      unidades_sig = BCD_NUEVE;
    end
`ifdef BLANQUEO_CEROS_EN
    // Saturated 999 never has a zero hundreds digit, so it is never blanked.
    if (centenas_sig == 4'd0) begin
      centenas_sig = BCD_BLANCO;
      if (decenas_sig == 4'd0) decenas_sig = BCD_BLANCO;
    end
`endif
  end

  // Output registers and the one-cycle done pulse, updated only on FIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      listo    <= 1'b0;
      centenas <= RST_ALTOS;
      decenas  <= RST_ALTOS;
      unidades <= 4'd0;
      desborde <= 1'b0;
    end else begin
      listo <= publicar;
      if (publicar) begin
        centenas <= centenas_sig;
        decenas  <= decenas_sig;
        unidades <= unidades_sig;
        desborde <= desborde_sig;
      end
    end
  end

endmodule

// File: tb/tb_binario_a_bcd_seq.sv
// Directed bench for binario_a_bcd_seq: a table of values with hand-computed
// digits, plus sequences for ignored restarts, back-to-back and continuous
// requests, and reset during a conversion.
module tb_binario_a_bcd_seq;

  localparam int ANCHO = 10;
  localparam int LAT   = ANCHO + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [ANCHO-1:0] binario;
  logic             inicio;
  logic             ocupado;
  logic             listo;
  logic [3:0]       unidades;
  logic [3:0]       decenas;
  logic [3:0]       centenas;
  logic             desborde;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         valor;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] u;
    logic       desb;
  } vector_t;

  vector_t tabla [10];

  binario_a_bcd_seq #(.ANCHO_BIN(ANCHO)) dut (
    .clk      (clk),
    .rst      (rst),
    .binario  (binario),
    .inicio   (inicio),
    .ocupado  (ocupado),
    .listo    (listo),
    .unidades (unidades),
    .decenas  (decenas),
    .centenas (centenas),
    .desborde (desborde)
  );

  always #5 clk = ~clk;

  task automatic check(input string nombre, input logic [31:0] actual,
                       input logic [31:0] esperado);
    checks++;
    if (actual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nombre, actual, esperado);
    end
  endtask

  // Expected display digits {c,d,u}, blanked when the build enables it.
  function automatic logic [11:0] vista(input logic [3:0] c, input logic [3:0] d,
                                        input logic [3:0] u);
    logic [3:0] cc;
    logic [3:0] dd;
    cc = c;
    dd = d;
`ifdef BLANQUEO_CEROS_EN
    if (cc == 4'd0) begin
      cc = 4'hF;
      if (dd == 4'd0) dd = 4'hF;
    end
`endif
    return {cc, dd, u};
  endfunction

  task automatic check_digitos(input string nombre, input logic [3:0] c,
                               input logic [3:0] d, input logic [3:0] u,
                               input logic desb);
    check({nombre, " digits"}, {20'd0, centenas, decenas, unidades}, {20'd0, vista(c, d, u)});
    check({nombre, " desborde"}, {31'd0, desborde}, {31'd0, desb});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepting edge with the given value; inicio drops afterwards.
  task automatic start(input int v);
    binario = ANCHO'(v);
    inicio  = 1'b1;
    step();
    inicio  = 1'b0;
  endtask

  // Steps until listo is seen (bounded), noting whether ocupado stayed high.
  task automatic wait_listo(output int n, output bit ocup_ok);
    n       = 0;
    ocup_ok = 1'b1;
    while (listo !== 1'b1 && n < 40) begin
      if (ocupado !== 1'b1) ocup_ok = 1'b0;
      step();
      n++;
    end
  endtask

  initial begin
    int  n;
    int  n2;
    bit  ok;
    bit  visto;
    logic [11:0] ultimo;

    tabla[0] = '{0,    4'd0, 4'd0, 4'd0, 1'b0};
    tabla[1] = '{255,  4'd2, 4'd5, 4'd5, 1'b0};
    tabla[2] = '{999,  4'd9, 4'd9, 4'd9, 1'b0};
    tabla[3] = '{1000, 4'd9, 4'd9, 4'd9, 1'b1};
    tabla[4] = '{1023, 4'd9, 4'd9, 4'd9, 1'b1};
    tabla[5] = '{7,    4'd0, 4'd0, 4'd7, 1'b0};
    tabla[6] = '{40,   4'd0, 4'd4, 4'd0, 1'b0};
    tabla[7] = '{105,  4'd1, 4'd0, 4'd5, 1'b0};
    tabla[8] = '{500,  4'd5, 4'd0, 4'd0, 1'b0};
    tabla[9] = '{99,   4'd0, 4'd9, 4'd9, 1'b0};

    rst     = 1'b1;
    inicio  = 1'b0;
    binario = '0;
    repeat (2) step();
    check_digitos("reset", 4'd0, 4'd0, 4'd0, 1'b0);
    check("reset listo", {31'd0, listo}, 32'd0);
    check("reset ocupado", {31'd0, ocupado}, 32'd0);
    rst = 1'b0;
    step();

    // Table-driven conversions.
    for (int i = 0; i < 10; i++) begin
      start(tabla[i].valor);
      wait_listo(n, ok);
      check($sformatf("v%0d latency", tabla[i].valor), n, LAT);
      check($sformatf("v%0d ocupado busy", tabla[i].valor), {31'd0, ok}, 32'd1);
      check($sformatf("v%0d ocupado at listo", tabla[i].valor), {31'd0, ocupado}, 32'd0);
      check_digitos($sformatf("v%0d", tabla[i].valor), tabla[i].c, tabla[i].d,
                    tabla[i].u, tabla[i].desb);
      ultimo = {centenas, decenas, unidades};
      step();
      check($sformatf("v%0d listo pulse", tabla[i].valor), {31'd0, listo}, 32'd0);
      check($sformatf("v%0d hold", tabla[i].valor), {20'd0, centenas, decenas, unidades},
            {20'd0, vista(tabla[i].c, tabla[i].d, tabla[i].u)});
      if (i == 0) check("v0 hold vs listo", {20'd0, ultimo}, {20'd0, vista(4'd0, 4'd0, 4'd0)});
    end

    // Restart request during a conversion is ignored, binario change too.
    start(123);
    repeat (3) step();
    binario = ANCHO'(456);
    inicio  = 1'b1;
    step();
    inicio  = 1'b0;
    wait_listo(n, ok);
    check("ignored restart latency", n + 4, LAT);
    check_digitos("ignored restart", 4'd1, 4'd2, 4'd3, 1'b0);

    // Request in the listo cycle is accepted: back-to-back conversion.
    start(456);
    wait_listo(n, ok);
    check("back-to-back latency", n, LAT);
    check_digitos("back-to-back", 4'd4, 4'd5, 4'd6, 1'b0);
    step();

    // inicio held high: conversions repeat every ANCHO+2 cycles.
    binario = ANCHO'(7);
    inicio  = 1'b1;
    step();
    wait_listo(n, ok);
    check("held first latency", n, LAT);
    step();
    wait_listo(n2, ok);
    inicio = 1'b0;
    check("held period", n2 + 1, ANCHO + 2);
    check_digitos("held", 4'd0, 4'd0, 4'd7, 1'b0);
    step();

    // Reset in the middle of a conversion aborts it without a listo pulse.
    start(321);
    repeat (4) step();
    rst = 1'b1;
    #1;
    check_digitos("mid reset", 4'd0, 4'd0, 4'd0, 1'b0);
    check("mid reset listo", {31'd0, listo}, 32'd0);
    check("mid reset ocupado", {31'd0, ocupado}, 32'd0);
    step();
    rst   = 1'b0;
    visto = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (listo === 1'b1) visto = 1'b1;
    end
    check("no listo after reset", {31'd0, visto}, 32'd0);
    start(42);
    wait_listo(n, ok);
    check("after reset latency", n, LAT);
    check_digitos("after reset", 4'd0, 4'd4, 4'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/binario_a_bcd_seq.md
Name: binario_a_bcd_seq

Overview:
Sequential binary-to-BCD converter that feeds the unidades/decenas/centenas inputs of the 7-segment display multiplexer.
- Implements the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Uses a start/busy/done handshake.
- Holds the last result stable between conversions.
- Sits between arithmetic or counter logic and the display driver.

Parameters:
ANCHO_BIN, 10, width of the binary input; legal range 4..13. Four internal BCD digits are enough for 13 bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
binario  input  ANCHO_BIN  unsigned value to convert, sampled only on the accepting edge
inicio  input  1  start request, level-sampled each rising edge
ocupado  output  1  high while a conversion is in progress
listo  output  1  one-cycle pulse when the digit outputs have been updated
unidades  output  4  BCD units digit
decenas  output  4  BCD tens digit
centenas  output  4  BCD hundreds digit
desborde  output  1  high when the last converted value was >= 1000

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values (no feature macro): all outputs 0, i.e. display shows 000. State goes to REPOSO; internal shift register and counter are cleared.
- States: REPOSO, CONVIERTE, FIN.
- REPOSO:
  - ocupado=0.
  - On an edge with inicio=1: load the shift register with {16'b0, binario}, clear the bit counter, go to CONVIERTE.
- CONVIERTE:
  - ocupado=1.
  - Each edge: for each of the 4 BCD nibbles, if nibble >= 5 add 3; then shift the whole register left by 1; counter +1.
  - When the counter reaches ANCHO_BIN-1 on the current edge, the final shift is done and the state goes to FIN.
  - Counter width is $clog2(ANCHO_BIN+1).
- FIN:
  - ocupado=1.
  - On the next edge, register the outputs, pulse listo=1 for exactly one cycle, and return to REPOSO.
- Latency: inicio sampled at edge 0; shifts on edges 1..ANCHO_BIN; outputs update and listo rises after edge ANCHO_BIN+1.
  - For ANCHO_BIN=10: listo is high in the cycle following edge 11.
- Overflow: if the thousands nibble is nonzero, load unidades=decenas=centenas=9 and desborde=1. Otherwise load the three low digits and desborde=0.
- inicio while ocupado=1: ignored, with no queueing. binario changes during a conversion have no effect.
- inicio high in the same cycle listo is high (state already REPOSO): accepted, so back-to-back conversions are allowed.
- inicio held high continuously: conversions repeat with a period of ANCHO_BIN+2 cycles.
- Reset mid-conversion: aborts immediately. Outputs, listo and ocupado take their reset values, and no listo pulse is emitted.
- Output registers change only on the FIN edge or reset; they are glitch-free for the display multiplexer.

Optional Feature:
BLANQUEO_CEROS_EN
- Defined: leading-zero blanking on the FIN edge.
  - If centenas=0, centenas is driven to 4'b1111 (the display decoder shows that as all segments off).
  - If centenas=0 and decenas=0, decenas is also driven to 4'b1111.
  - unidades is never blanked.
  - Reset values become centenas=decenas=4'b1111, unidades=0.
  - Overflow saturation (999) is unaffected.
- Undefined: plain BCD digits, reset to 0.

Decomposition:
Shared package binario_a_bcd_pkg:
- State encoding constants for REPOSO, CONVIERTE and FIN.
- NUM_DIGITOS=4.
- BCD_BLANCO=4'b1111.
- BCD_NUEVE=4'b1001.

Sub-module celda_suma3: purely combinational, 4-bit in / 4-bit out, adds 3 when the input is >= 5. It is instantiated NUM_DIGITOS times inside the CONVIERTE datapath.

Test Plan:
- binario=0, pulse inicio -> listo after 11 cycles; digits 0,0,0; desborde=0; ocupado high for cycles 1..11.
- binario=255 -> centenas=2, decenas=5, unidades=5. binario=999 -> 9,9,9 with desborde=0.
- binario=1000 and binario=1023 -> 9,9,9 with desborde=1. A following binario=7 -> 0,0,7 with desborde=0.
- Conversion of 123 started; inicio re-pulsed with binario=456 at cycle 4 -> single listo, result 1,2,3. inicio with 456 during the listo cycle -> second listo 12 cycles later, result 4,5,6.
- Assert rst at cycle 5 of a conversion of 321 -> outputs immediately 0, ocupado=0, no listo; a subsequent conversion of 42 -> 0,4,2.
- With BLANQUEO_CEROS_EN: 7 -> F,F,7; 40 -> F,4,0; 105 -> 1,0,5; 0 -> F,F,0.
